// File: rtl/mips_defs.sv
// mips_defs: shared definitions for the MIPS32 execute stage.
// Holds ALU type codes, ALU opcodes, the execute-stage FSM state enum and
// two small datapath helpers (operand magnitude and the single-cycle ALU).
package mips_defs;

  // ALU type codes produced by the decoder
  localparam logic [2:0] ALUTYPE_NONE  = 3'b000;
  localparam logic [2:0] ALUTYPE_ARITH = 3'b001;
  localparam logic [2:0] ALUTYPE_LOGIC = 3'b010;
  localparam logic [2:0] ALUTYPE_MOVE  = 3'b011;
  localparam logic [2:0] ALUTYPE_SHIFT = 3'b100;

  // ALU opcodes
  localparam logic [7:0] EXE_ADD   = 8'h18;
  localparam logic [7:0] EXE_ADDIU = 8'h19;
  localparam logic [7:0] EXE_SUBU  = 8'h1B;
  localparam logic [7:0] EXE_SLT   = 8'h26;
  localparam logic [7:0] EXE_SLTIU = 8'h27;
  localparam logic [7:0] EXE_AND   = 8'h1C;
  localparam logic [7:0] EXE_ORI   = 8'h1D;
  localparam logic [7:0] EXE_LUI   = 8'h05;
  localparam logic [7:0] EXE_SLL   = 8'h11;
  localparam logic [7:0] EXE_MFHI  = 8'h0C;
  localparam logic [7:0] EXE_MFLO  = 8'h0D;
  localparam logic [7:0] EXE_MULT  = 8'h14;
  localparam logic [7:0] EXE_LB    = 8'h90;
  localparam logic [7:0] EXE_LW    = 8'h92;
  localparam logic [7:0] EXE_SB    = 8'h98;
  localparam logic [7:0] EXE_SW    = 8'h9A;

  // Execute-stage multiply sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } exe_state_e;

  // Magnitude of a signed 32-bit value; 33 bits so that |0x80000000| = 2^31 fits.
  function automatic logic [32:0] mag33(input logic [31:0] v);
    logic [32:0] m;
    if (v[31]) begin
      m = 33'd0 - {1'b1, v};
    end else begin
      m = {1'b0, v};
    end
    return m;
  endfunction

  // Single-cycle ALU result for every non-multiply opcode; unknown opcodes give 0.
  function automatic logic [31:0] alu_result(input logic [7:0]  op,
                                             input logic [31:0] s1,
                                             input logic [31:0] s2,
                                             input logic [31:0] hi,
                                             input logic [31:0] lo);
    logic [31:0] r;
    r = 32'd0;
    case (op)
      EXE_ADD, EXE_ADDIU,
      EXE_LB, EXE_LW, EXE_SB, EXE_SW: r = s1 + s2;
      EXE_SUBU:                       r = s1 - s2;
      EXE_SLT:                        r = {31'd0, ($signed(s1) < $signed(s2))};
      EXE_SLTIU:                      r = {31'd0, (s1 < s2)};
      EXE_AND:                        r = s1 & s2;
      EXE_ORI:                        r = s1 | s2;
      EXE_LUI:                        r = s2;
      EXE_SLL:                        r = s2 << s1[4:0];
      EXE_MFHI:                       r = hi;
      EXE_MFLO:                       r = lo;
      default:                        r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// mul_iter: signed 32x32 iterative shift-add multiplier.
// start latches operand magnitudes and the result sign; each following cycle
// retires MUL_BITS_PER_CYCLE multiplier bits. done is high during the final
// iteration, so product is valid from the next cycle until the next start.
// flush abandons an iteration sequence in progress.
module mul_iter
  import mips_defs::*;
#(
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        done,
  output logic [63:0] product
);

  localparam int         ITERS    = 32 / MUL_BITS_PER_CYCLE;
  localparam logic [4:0] LAST_CNT = 5'(ITERS - 1);

  logic        run_r;
  logic [4:0]  cnt_r;
  logic [32:0] mcand_r;
  logic [32:0] mplier_r;
  logic [63:0] acc_r;
  logic        sign_r;
  logic [5:0]  shamt_s;
  logic [63:0] sum_s;

  assign shamt_s = 6'(cnt_r) * 6'(MUL_BITS_PER_CYCLE);
  assign done    = run_r & (cnt_r == LAST_CNT);
  assign product = sign_r ? (64'd0 - acc_r) : acc_r;

  // Partial-product accumulation for the multiplier bits retired this cycle
  always_comb begin
    sum_s = acc_r;
    for (int k = 0; k < MUL_BITS_PER_CYCLE; k++) begin
      if (mplier_r[k]) begin
        sum_s = sum_s + ({31'd0, mcand_r} << (shamt_s + 6'(k)));
      end else begin
        sum_s = sum_s;
      end
    end
  end

  // Operand latch, iteration counter and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r    <= 1'b0;
      cnt_r    <= 5'd0;
      mcand_r  <= 33'd0;
      mplier_r <= 33'd0;
      acc_r    <= 64'd0;
      sign_r   <= 1'b0;
    end else if (start) begin
      run_r    <= 1'b1;
      cnt_r    <= 5'd0;
      mcand_r  <= mag33(src_a);
      mplier_r <= mag33(src_b);
      acc_r    <= 64'd0;
      sign_r   <= src_a[31] ^ src_b[31];
    end else if (flush) begin
      run_r <= 1'b0;
      cnt_r <= 5'd0;
    end else if (run_r) begin
      acc_r    <= sum_s;
      mplier_r <= mplier_r >> MUL_BITS_PER_CYCLE;
      cnt_r    <= cnt_r + 5'd1;
      run_r    <= (cnt_r != LAST_CNT);
    end
  end

endmodule

// File: rtl/exe_stage.sv
// exe_stage: MIPS32 execute stage. Computes ALU results / memory addresses in
// one cycle and the HI/LO product of MULT, registering everything into the
// EXE/MEM boundary.
// Build option: define EXE_FAST_MULT_EN for a single-cycle combinational
// multiply (no stall). Otherwise MULT uses mul_iter and stalls the front end
// for 32/MUL_BITS_PER_CYCLE+1 cycles, delivering HI/LO after 32/N+2 cycles.
module exe_stage
  import mips_defs::*;
#(
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid_i,
  input  logic [2:0]  id_alutype_i,
  input  logic [7:0]  id_aluop_i,
  input  logic [31:0] id_src1_i,
  input  logic [31:0] id_src2_i,
  input  logic        id_wreg_i,
  input  logic        id_mreg_i,
  input  logic        id_whilo_i,
  input  logic [4:0]  id_wa_i,
  input  logic [31:0] id_din_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        flush_i,
  output logic        stall_req_o,
  output logic [7:0]  exe_aluop_o,
  output logic [4:0]  exe_wa_o,
  output logic        exe_wreg_o,
  output logic        exe_mreg_o,
  output logic        exe_whilo_o,
  output logic [31:0] exe_wd_o,
  output logic [31:0] exe_din_o,
  output logic [63:0] exe_hilo_o
);

  logic        is_mult_s;
  logic        issue_s;
  logic        done_fire_s;
  logic        stall_s;
  logic [63:0] prod_s;

  logic [7:0]  aluop_s;
  logic [4:0]  wa_s;
  logic        wreg_s;
  logic        mreg_s;
  logic        whilo_s;
  logic [31:0] wd_s;
  logic [31:0] din_s;
  logic [63:0] hilo_s;

  assign is_mult_s = (id_aluop_i == EXE_MULT);

`ifdef EXE_FAST_MULT_EN

  logic signed [63:0] fast_prod_s;

  assign fast_prod_s = $signed(id_src1_i) * $signed(id_src2_i);
  assign prod_s      = fast_prod_s;
  assign issue_s     = id_valid_i & ~flush_i;
  assign done_fire_s = issue_s & is_mult_s;
  assign stall_s     = 1'b0;

`else

  exe_state_e state_r;
  exe_state_e state_nxt_s;
  logic       start_s;
  logic       mul_done_s;

  assign issue_s     = id_valid_i & ~flush_i & (state_r == ST_IDLE);
  assign start_s     = issue_s & is_mult_s;
  assign done_fire_s = (state_r == ST_DONE) & ~flush_i;

  mul_iter #(
    .MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)
  ) u_mul_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_s),
    .flush   (flush_i),
    .src_a   (id_src1_i),
    .src_b   (id_src2_i),
    .done    (mul_done_s),
    .product (prod_s)
  );

  // Multiply sequencing state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and front-end stall request; stall holds from the issue cycle to the last iteration
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = ST_BUSY;
          stall_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        stall_s = ~flush_i;
        if (flush_i) begin
          state_nxt_s = ST_IDLE;
        end else if (mul_done_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

`endif

  // Stall is forced low while reset is asserted, even if a MULT bundle is presented
  assign stall_req_o = rst_n & stall_s;

  // Next EXE/MEM contents: product write, ALU/address result, or bubble
  always_comb begin
    aluop_s = 8'd0;
    wa_s    = 5'd0;
    wreg_s  = 1'b0;
    mreg_s  = 1'b0;
    whilo_s = 1'b0;
    wd_s    = 32'd0;
    din_s   = 32'd0;
    hilo_s  = exe_hilo_o;
    if (done_fire_s) begin
      aluop_s = EXE_MULT;
      whilo_s = 1'b1;
      hilo_s  = prod_s;
    end else if (issue_s && !is_mult_s) begin
      aluop_s = id_aluop_i;
      wa_s    = id_wa_i;
      wreg_s  = id_wreg_i;
      mreg_s  = id_mreg_i;
      whilo_s = id_whilo_i;
      din_s   = id_din_i;
      // a bundle typed "none" carries no result
      wd_s    = (id_alutype_i == ALUTYPE_NONE) ? 32'd0
              : alu_result(id_aluop_i, id_src1_i, id_src2_i, hi_i, lo_i);
    end else begin
      aluop_s = 8'd0;
      whilo_s = 1'b0;
    end
  end

  // EXE/MEM boundary register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_aluop_o <= 8'd0;
      exe_wa_o    <= 5'd0;
      exe_wreg_o  <= 1'b0;
      exe_mreg_o  <= 1'b0;
      exe_whilo_o <= 1'b0;
      exe_wd_o    <= 32'd0;
      exe_din_o   <= 32'd0;
      exe_hilo_o  <= 64'd0;
    end else begin
      exe_aluop_o <= aluop_s;
      exe_wa_o    <= wa_s;
      exe_wreg_o  <= wreg_s;
      exe_mreg_o  <= mreg_s;
      exe_whilo_o <= whilo_s;
      exe_wd_o    <= wd_s;
      exe_din_o   <= din_s;
      exe_hilo_o  <= hilo_s;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: self-checking bench for exe_stage (iterative multiplier build).
module tb_exe_stage;

  localparam int MB    = 1;
  localparam int ITERS = 32 / MB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid_i;
  logic [2:0]  id_alutype_i;
  logic [7:0]  id_aluop_i;
  logic [31:0] id_src1_i;
  logic [31:0] id_src2_i;
  logic        id_wreg_i;
  logic        id_mreg_i;
  logic        id_whilo_i;
  logic [4:0]  id_wa_i;
  logic [31:0] id_din_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        flush_i;
  logic        stall_req_o;
  logic [7:0]  exe_aluop_o;
  logic [4:0]  exe_wa_o;
  logic        exe_wreg_o;
  logic        exe_mreg_o;
  logic        exe_whilo_o;
  logic [31:0] exe_wd_o;
  logic [31:0] exe_din_o;
  logic [63:0] exe_hilo_o;

  always #5 clk = ~clk;

  exe_stage #(.MUL_BITS_PER_CYCLE(MB)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .id_alutype_i(id_alutype_i),
    .id_aluop_i(id_aluop_i), .id_src1_i(id_src1_i), .id_src2_i(id_src2_i),
    .id_wreg_i(id_wreg_i), .id_mreg_i(id_mreg_i), .id_whilo_i(id_whilo_i),
    .id_wa_i(id_wa_i), .id_din_i(id_din_i), .hi_i(hi_i), .lo_i(lo_i),
    .flush_i(flush_i), .stall_req_o(stall_req_o), .exe_aluop_o(exe_aluop_o),
    .exe_wa_o(exe_wa_o), .exe_wreg_o(exe_wreg_o), .exe_mreg_o(exe_mreg_o),
    .exe_whilo_o(exe_whilo_o), .exe_wd_o(exe_wd_o), .exe_din_o(exe_din_o),
    .exe_hilo_o(exe_hilo_o)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_hilo = 64'd0;
  logic [7:0]  known_ops [0:14] = '{8'h18, 8'h19, 8'h1B, 8'h26, 8'h27, 8'h1C, 8'h1D, 8'h05,
                                   8'h11, 8'h0C, 8'h0D, 8'h90, 8'h92, 8'h98, 8'h9A};

  // Decoder-consistent ALU type for an opcode
  function automatic logic [2:0] op_type(input logic [7:0] op);
    case (op)
      8'h14:                       return 3'b000;
      8'h1C, 8'h1D, 8'h05:         return 3'b010;
      8'h0C, 8'h0D:                return 3'b011;
      8'h11:                       return 3'b100;
      default:                     return 3'b001;
    endcase
  endfunction

  // Reference result using 64-bit integer arithmetic reduced modulo 2^32
  function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [31:0] s1, s2, hi, lo);
    longint unsigned a, b, m;
    a = s1; b = s2; m = 64'h1_0000_0000;
    case (op)
      8'h18, 8'h19, 8'h90, 8'h92, 8'h98, 8'h9A: return 32'((a + b) % m);
      8'h1B: return 32'((a + m - b) % m);
      8'h26: return (int'(s1) < int'(s2)) ? 32'd1 : 32'd0;
      8'h27: return (a < b) ? 32'd1 : 32'd0;
      8'h1C: return s1 & s2;
      8'h1D: return s1 | s2;
      8'h05: return s2;
      8'h11: return 32'((b * (64'd1 << (a % 64'd32))) % m);
      8'h0C: return hi;
      8'h0D: return lo;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [63:0] ref_mul(input logic [31:0] a, b);
    longint p;
    p = longint'(int'(a)) * longint'(int'(b));
    return 64'(p);
  endfunction

  task automatic drive(input logic v, input logic [7:0] op, input logic [31:0] s1, s2,
                       input logic wr, mr, input logic [4:0] wa, input logic [31:0] din);
    id_valid_i   = v;
    id_aluop_i   = op;
    id_alutype_i = op_type(op);
    id_src1_i    = s1;
    id_src2_i    = s2;
    id_wreg_i    = wr;
    id_mreg_i    = mr;
    id_whilo_i   = (op == 8'h14);
    id_wa_i      = wa;
    id_din_i     = din;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush_i = 1'b0; hi_i = 32'd0; lo_i = 32'd0;
    drive(1'b0, 8'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({stall_req_o, exe_aluop_o, exe_wa_o, exe_wreg_o, exe_mreg_o, exe_whilo_o,
         exe_wd_o, exe_din_o, exe_hilo_o} !== 146'd0) begin
      errors++;
      $display("FAIL reset: stall=%b wd=%h hilo=%h aluop=%h, required all zero",
               stall_req_o, exe_wd_o, exe_hilo_o, exe_aluop_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_alu_directed;
    logic [7:0]  op  [0:8] = '{8'h18, 8'h26, 8'h27, 8'h11, 8'h92, 8'h1B, 8'h05, 8'h0C, 8'h3F};
    logic [31:0] s1  [0:8] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h4, 32'h1000,
                               32'h5, 32'h0, 32'h0, 32'h1234};
    logic [31:0] s2  [0:8] = '{32'h1, 32'h1, 32'h1, 32'hF, 32'hFFFFFFFC, 32'h7,
                               32'h12340000, 32'h0, 32'h5678};
    logic        mr  [0:8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] wd  [0:8] = '{32'h80000000, 32'h1, 32'h0, 32'hF0, 32'hFFC, 32'hFFFFFFFE,
                               32'h12340000, 32'hAAAA5555, 32'h0};
    logic [31:0] din;
    logic [4:0]  wa;
    hi_i = 32'hAAAA5555; lo_i = 32'h12345678;
    for (int i = 0; i < 9; i++) begin
      din = $urandom;
      wa  = (i == 0) ? 5'd5 : 5'($urandom_range(1, 31));
      drive(1'b1, op[i], s1[i], s2[i], 1'b1, mr[i], wa, din);
      @(posedge clk);
      #1;
      checks++;
      if ({exe_wd_o, exe_wreg_o, exe_mreg_o, exe_whilo_o, exe_wa_o, exe_aluop_o, exe_din_o} !==
          {wd[i], 1'b1, mr[i], 1'b0, wa, op[i], din}) begin
        errors++;
        $display("FAIL alu_directed[%0d] op=%h: got wd=%h wreg=%b mreg=%b wa=%0d, required wd=%h mreg=%b wa=%0d",
                 i, op[i], exe_wd_o, exe_wreg_o, exe_mreg_o, exe_wa_o, wd[i], mr[i], wa);
      end
    end
    drive(1'b0, 8'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_alu_random;
    logic [143:0] exp_v, got_v;
    logic [7:0]   op;
    logic [31:0]  s1, s2, din;
    logic         v, fl, wr, mr;
    logic [4:0]   wa;
    int           kind;
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
        0: op = 8'h00;
        1: op = 8'h3F;
        2: op = 8'hFF;
        default: op = 8'h21;
      endcase
      if (kind != 9) op = known_ops[$urandom_range(0, 14)];
      v  = (kind != 0);
      fl = (kind == 1);
      s1 = $urandom; s2 = $urandom; din = $urandom;
      if ($urandom_range(0, 3) == 0) s2 = s1;
      wr = 1'($urandom); mr = 1'($urandom); wa = 5'($urandom);
      hi_i = $urandom; lo_i = $urandom;
      drive(v, op, s1, s2, wr, mr, wa, din);
      flush_i = fl;
      if (v && !fl) exp_v = {op, wa, wr, mr, 1'b0, ref_alu(op, s1, s2, hi_i, lo_i), din, exp_hilo};
      else          exp_v = {8'd0, 5'd0, 3'b000, 32'd0, 32'd0, exp_hilo};
      @(posedge clk);
      #1;
      got_v = {exe_aluop_o, exe_wa_o, exe_wreg_o, exe_mreg_o, exe_whilo_o, exe_wd_o, exe_din_o, exe_hilo_o};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL alu_random[%0d] op=%h v=%b flush=%b: got %h, required %h", i, op, v, fl, got_v, exp_v);
      end
    end
    flush_i = 1'b0;
    drive(1'b0, 8'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_mult(input logic [31:0] a, b);
    logic [63:0] want;
    logic [31:0] add_a, add_b;
    int          n;
    logic        bad;
    want = ref_mul(a, b);
    drive(1'b1, 8'h14, a, b, 1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if (stall_req_o !== 1'b1) begin
      errors++;
      $display("FAIL mult_stall_issue %h*%h: stall=%b, required 1", a, b, stall_req_o);
    end
    n = 0; bad = 1'b0;
    while (stall_req_o === 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (exe_whilo_o !== 1'b0 || exe_wreg_o !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (n != ITERS + 1 || bad) begin
      errors++;
      $display("FAIL mult_stall_len %h*%h: stalled %0d cycles (bubble_err=%b), required %0d cycles of bubbles",
               a, b, n, bad, ITERS + 1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (exe_whilo_o !== 1'b1 || exe_hilo_o !== want || exe_wreg_o !== 1'b0) begin
      errors++;
      $display("FAIL mult_result %h*%h: whilo=%b hilo=%h wreg=%b, required whilo=1 hilo=%h wreg=0",
               a, b, exe_whilo_o, exe_hilo_o, exe_wreg_o, want);
    end
    exp_hilo = want;
    add_a = $urandom; add_b = $urandom;
    drive(1'b1, 8'h18, add_a, add_b, 1'b1, 1'b0, 5'd9, 32'd0);
    @(posedge clk);
    #1;
    checks++;
    if (exe_whilo_o !== 1'b0 || exe_hilo_o !== exp_hilo || exe_wd_o !== ref_alu(8'h18, add_a, add_b, 32'd0, 32'd0)) begin
      errors++;
      $display("FAIL mult_followup: whilo=%b hilo=%h wd=%h, required whilo=0 hilo=%h wd=%h",
               exe_whilo_o, exe_hilo_o, exe_wd_o, exp_hilo, ref_alu(8'h18, add_a, add_b, 32'd0, 32'd0));
    end
    drive(1'b0, 8'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_flush_busy;
    logic seen;
    drive(1'b1, 8'h14, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    flush_i = 1'b1;
    #1;
    checks++;
    if (stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: stall=%b, required 0", stall_req_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({exe_whilo_o, exe_wreg_o, exe_aluop_o, exe_hilo_o} !== {1'b0, 1'b0, 8'd0, exp_hilo}) begin
      errors++;
      $display("FAIL flush_bubble: whilo=%b wreg=%b aluop=%h hilo=%h, required bubble with hilo=%h",
               exe_whilo_o, exe_wreg_o, exe_aluop_o, exe_hilo_o, exp_hilo);
    end
    flush_i = 1'b0;
    drive(1'b1, 8'h18, 32'd100, 32'd23, 1'b1, 1'b0, 5'd7, 32'd0);
    @(posedge clk);
    #1;
    checks++;
    if ({exe_wd_o, exe_wreg_o, exe_wa_o} !== {32'd123, 1'b1, 5'd7}) begin
      errors++;
      $display("FAIL flush_next_add: wd=%h wreg=%b wa=%0d, required wd=0000007b wreg=1 wa=7",
               exe_wd_o, exe_wreg_o, exe_wa_o);
    end
    drive(1'b0, 8'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (exe_whilo_o !== 1'b0 || stall_req_o !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush_no_whilo: late whilo/stall observed=%b, required 0", seen);
    end
  endtask

  task automatic test_reset_mid_busy;
    logic bad;
    drive(1'b1, 8'h14, 32'hFFFF0000, 32'h00010003, 1'b0, 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    bad = 1'b0;
    if ({stall_req_o, exe_aluop_o, exe_wa_o, exe_wreg_o, exe_mreg_o, exe_whilo_o,
         exe_wd_o, exe_din_o, exe_hilo_o} !== 146'd0) bad = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if ({stall_req_o, exe_whilo_o, exe_hilo_o} !== 66'd0) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_mid_busy: stall=%b whilo=%b hilo=%h, required all zero", stall_req_o, exe_whilo_o, exe_hilo_o);
    end
    exp_hilo = 64'd0;
    rst_n = 1'b1;
    drive(1'b1, 8'h1D, 32'hF0F00000, 32'h0000AAAA, 1'b1, 1'b0, 5'd3, 32'd0);
    #1;
    checks++;
    if (stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_stall: stall=%b, required 0", stall_req_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({exe_wd_o, exe_wreg_o, exe_wa_o, exe_hilo_o} !== {32'hF0F0AAAA, 1'b1, 5'd3, 64'd0}) begin
      errors++;
      $display("FAIL reset_release_ori: wd=%h wreg=%b wa=%0d hilo=%h, required wd=f0f0aaaa wreg=1 wa=3 hilo=0",
               exe_wd_o, exe_wreg_o, exe_wa_o, exe_hilo_o);
    end
    drive(1'b0, 8'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    test_reset();
    test_alu_directed();
    test_alu_random();
    test_mult(32'hFFFFFFFE, 32'h00000003);
    test_mult(32'h80000000, 32'h80000000);
    test_mult(32'h00000000, 32'h80000000);
    test_mult(32'h7FFFFFFF, 32'h80000000);
    for (int i = 0; i < 3; i++) test_mult($urandom, $urandom);
    test_flush_busy();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage MIPS32 pipeline. Sits directly downstream of the decoder and consumes its decoded bundle: ALU type/op, src1/src2, write controls, store data.
- Computes the ALU result, the load/store address, or the HI/LO product.
- Registers everything into the EXE/MEM boundary.
- MULT runs on an iterative multiplier that stalls the front end until done.

Parameters:
- MUL_BITS_PER_CYCLE, 1, multiplier bits retired per iteration (1, 2 or 4). Iterations = 32/MUL_BITS_PER_CYCLE.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_valid_i  in  1  decoded bundle valid this cycle
- id_alutype_i  in  3  ALU type: 000 none/mult, 001 arith, 010 logic, 011 move, 100 shift
- id_aluop_i  in  8  ALU opcode (codes below)
- id_src1_i  in  32  operand 1 (rs value or shift amount)
- id_src2_i  in  32  operand 2 (rt value or extended immediate)
- id_wreg_i, id_mreg_i, id_whilo_i  in  1 each  write-reg, load, write-HI/LO
- id_wa_i  in  5  destination register
- id_din_i  in  32  store data
- hi_i, lo_i  in  32 each  current HI/LO register contents
- flush_i  in  1  kill the current bundle and any in-flight multiply
- stall_req_o  out  1  hold decode and fetch
- exe_aluop_o  out  8  forwarded opcode, used by MEM for lb/lw/sb/sw
- exe_wa_o  out  5
- exe_wreg_o, exe_mreg_o, exe_whilo_o  out  1 each
- exe_wd_o  out  32  ALU result or memory address
- exe_din_o  out  32  store data
- exe_hilo_o  out  64  {HI,LO} product

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM IDLE, multiplier registers cleared. stall_req_o=0.
- Opcodes and results:
  - 0x18 add, 0x19 addiu: src1+src2, mod 2^32, no trap.
  - 0x1B subu: src1-src2.
  - 0x26 slt: signed compare, result {31'b0, src1<src2}.
  - 0x27 sltiu: unsigned compare, result {31'b0, src1<src2}.
  - 0x1C and: src1&src2.
  - 0x1D ori: src1|src2.
  - 0x05 lui: src2.
  - 0x11 sll: src2 << src1[4:0].
  - 0x0C mfhi: hi_i. 0x0D mflo: lo_i.
  - 0x90/0x92/0x98/0x9A (lb/lw/sb/sw): address src1+src2.
  - Unknown opcode: result 0.
- Non-MULT ops: one-cycle latency. Output register loads on every clk edge while IDLE.
- Bubble: id_valid_i=0 or flush_i=1 loads a bubble — wreg/mreg/whilo=0, wa/wd/din/aluop=0.
- FSM:
  - IDLE -> BUSY when id_valid_i & aluop==0x14 & !flush_i. On that edge, latch magnitudes |src1|, |src2| and the sign (src1[31]^src2[31]). Emit a bubble. stall_req_o is combinationally 1 in the same cycle.
  - BUSY: shift-add MUL_BITS_PER_CYCLE bits per cycle. stall_req_o=1. Output register emits bubbles. The decode bundle is held stable upstream and ignored.
  - BUSY -> DONE after the final iteration.
  - DONE: negate the 64-bit product if the sign bit is set. Register exe_hilo_o and exe_whilo_o=1 for exactly one cycle. stall_req_o=0 so the front end advances. Return to IDLE.
  - Total MULT latency: 32/MUL_BITS_PER_CYCLE+2 cycles.
- flush_i in BUSY or DONE: return to IDLE next edge, emit a bubble, whilo never asserted. stall_req_o drops in the flush cycle.
- Signed edge cases:
  - 0x80000000 magnitude is 2^31 and must be carried in a 33-bit magnitude register.
  - Any zero operand yields 0, never -0.
- exe_hilo_o holds its last value when exe_whilo_o=0. Only whilo qualifies it.

Optional Feature:
- Macro EXE_FAST_MULT_EN.
- Defined: MULT is a single-cycle combinational signed 32x32 multiply. No FSM, stall_req_o tied 0. Product registered with whilo=1 on the next edge.
- Undefined: iterative FSM as above, and MUL_BITS_PER_CYCLE applies.

Decomposition:
- Shared package mips_defs holds: ALU type constants, aluop codes (0x18, 0x1B, 0x26, 0x1C, 0x14, 0x0C, 0x0D, 0x11, 0x1D, 0x05, 0x19, 0x27, 0x90, 0x92, 0x98, 0x9A), and the FSM state enum (IDLE, BUSY, DONE).
- One sub-module, mul_iter: signed iterative multiplier with start/flush/done handshake and 64-bit product.

Test Plan:
- Reset mid-BUSY (rst_n low at iteration 10) -> all outputs 0, stall_req_o=0 immediately, FSM IDLE after release.
- add src1=0x7FFFFFFF, src2=1, wa=5 -> next cycle wd=0x80000000, wreg=1, wa=5. slt 0xFFFFFFFF vs 1 -> 1. sltiu same operands -> 0.
- sll src1=4, src2=0x0000000F -> 0x000000F0. lw src1=0x1000, src2=0xFFFFFFFC -> wd=0x00000FFC, mreg=1, wreg=1.
- mult 0xFFFFFFFE x 3 (MUL_BITS_PER_CYCLE=1) -> stall_req_o=1 for 33 cycles, then hilo=0xFFFFFFFF_FFFFFFFA with whilo=1 for one cycle.
- mult 0x80000000 x 0x80000000 -> hilo=0x40000000_00000000. mult 0 x 0x80000000 -> hilo=0.
- flush_i at BUSY iteration 5 -> stall_req_o falls in the flush cycle, whilo stays 0, the next add completes normally one cycle later.
